// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, bus owner, latched transfer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } xfer_t;

    // rr=0: data always wins a contest; rr=1: the side not granted last wins.
    function automatic owner_t pick_winner(input logic i_req, input logic d_req,
                                           input owner_t last, input logic rr);
        if (i_req && d_req)
            return (rr && last == OWN_D) ? OWN_I : OWN_D;
        return d_req ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and single-port memory bus of the arbiter.
// slave: arbiter view; master: requesters plus memory model view.
interface mem_arbiter_if;
    logic        i_stb;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_data;

    logic        d_cyc;
    logic        d_stb;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic        d_ack;
    logic        d_stall;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_sel;
    logic        m_ack;
    logic        m_stall;
    logic [31:0] m_rdata;

    modport slave (
        input  i_stb, i_addr,
        output i_ack, i_err, i_data,
        input  d_cyc, d_stb, d_we, d_addr, d_wdata, d_sel,
        output d_ack, d_stall, d_err, d_rdata,
        output m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel,
        input  m_ack, m_stall, m_rdata
    );

    modport master (
        output i_stb, i_addr,
        input  i_ack, i_err, i_data,
        output d_cyc, d_stb, d_we, d_addr, d_wdata, d_sel,
        input  d_ack, d_stall, d_err, d_rdata,
        input  m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel,
        output m_ack, m_stall, m_rdata
    );
endinterface

// File: rtl/mem_arb_timer.sv
// Transfer timeout counter: cleared on grant, counts every REQ/WAIT cycle.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; free-running while enabled.
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= 8'd0;
        else if (clr)
            count <= 8'd0;
        else if (en)
            count <= count + 8'd1;
    end

    // count holds the number of enabled cycles already elapsed
    assign expired = en && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one memory bus, one transfer outstanding (ARB_ROUND_ROBIN_EN: round-robin).
// Latency: grant in IDLE, m_stb next cycle; acks/errors are combinational from m_ack/timer.
// Backpressure: d_stall high unless data wins in IDLE; m_stall holds REQ; timeout aborts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_t state, state_nxt;
    owner_t owner, last_grant, winner;
    xfer_t  xfer, xfer_nxt;

    logic d_req;
    logic grant;
    logic expired;
    logic d_abort;
    logic acked;
    logic timed_out;

    assign d_req = bus.d_cyc & bus.d_stb;
    assign grant = (state == IDLE) & (bus.i_stb | d_req) & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
    assign winner = pick_winner(bus.i_stb, d_req, last_grant, 1'b1);
`else
    assign winner = pick_winner(bus.i_stb, d_req, last_grant, 1'b0);
`endif

    // A data owner dropping d_cyc abandons the transfer silently
    assign d_abort   = (state != IDLE) & (owner == OWN_D) & ~bus.d_cyc;
    assign acked     = (state == WAIT) & bus.m_ack & ~d_abort;
    assign timed_out = expired & ~acked & ~d_abort;

    mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant),
        .en      (state != IDLE),
        .expired (expired)
    );

    always_comb begin
        xfer_nxt = '0;
        if (winner == OWN_D) begin
            xfer_nxt.we    = bus.d_we;
            xfer_nxt.addr  = bus.d_addr;
            xfer_nxt.wdata = bus.d_wdata;
            xfer_nxt.sel   = bus.d_sel;
        end else begin
            xfer_nxt.addr  = bus.i_addr;
            xfer_nxt.sel   = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_I;
            last_grant <= OWN_I;
            xfer       <= '0;
        end else if (grant) begin
            owner      <= winner;
            last_grant <= winner;
            xfer       <= xfer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = REQ;
            REQ: begin
                if (d_abort || timed_out)
                    state_nxt = IDLE;
                else if (!bus.m_stall)
                    state_nxt = WAIT;
            end
            WAIT: if (d_abort || acked || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.m_cyc   = (state != IDLE);
        bus.m_stb   = (state == REQ);
        bus.m_we    = xfer.we;
        bus.m_addr  = xfer.addr;
        bus.m_wdata = xfer.wdata;
        bus.m_sel   = xfer.sel;

        bus.i_ack   = acked & (owner == OWN_I);
        bus.d_ack   = acked & (owner == OWN_D);
        bus.i_err   = timed_out & (owner == OWN_I);
        bus.d_err   = timed_out & (owner == OWN_D);
        bus.i_data  = bus.i_ack ? bus.m_rdata : 32'd0;
        bus.d_rdata = bus.d_ack ? bus.m_rdata : 32'd0;

        bus.d_stall = ~(grant & (winner == OWN_D));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transfers on both requesters against a transaction-level model of grant order, bus fields, acks and timeouts.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int TO = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester model
    bit          pend_i, pend_d, last_d, late_ack;
    logic [31:0] ia, da, dwd;
    bit          dwe;
    logic [3:0]  dsel;

    bit          win_d, never, abort;
    int          s, a, k, ab;
    logic [31:0] rdata, exp_addr;
    logic [36:0] exp_ctl;

    task automatic drive_reqs();
        bus.i_stb   = pend_i;
        bus.i_addr  = ia;
        bus.d_cyc   = pend_d;
        bus.d_stb   = pend_d;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.d_sel   = dsel;
    endtask

    task automatic new_fetch();
        pend_i = 1'b1;
        ia     = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_data();
        pend_d = 1'b1;
        da     = $urandom;
        dwd    = $urandom;
        dwe    = 1'($urandom_range(1, 0));
        dsel   = 4'($urandom_range(15, 1));
    endtask

    initial begin
        rst = 1'b1;
        pend_i = 0; pend_d = 0; last_d = 0; late_ack = 0;
        ia = 0; da = 0; dwd = 0; dwe = 0; dsel = 0;
        drive_reqs();
        bus.m_ack = 0; bus.m_stall = 0; bus.m_rdata = 0;

        repeat (2) @(negedge clk);
        // requests present while reset is held must not be granted
        bus.i_stb = 1; bus.d_cyc = 1; bus.d_stb = 1;
        #1;
        chk("rst_ctl", {bus.m_cyc, bus.m_stb}, 2'b00);
        chk("rst_resp", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 4'b0000);
        chk("rst_stall", bus.d_stall, 1'b1);
        @(negedge clk);
        #1;
        chk("rst_hold_cyc", bus.m_cyc, 1'b0);
        rst = 1'b0;
        drive_reqs();

        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            if (!pend_i && $urandom_range(1, 0) == 1) new_fetch();
            if (!pend_d && $urandom_range(1, 0) == 1) new_data();
            if (!pend_i && !pend_d) begin
                if ($urandom_range(1, 0) == 1) new_fetch(); else new_data();
            end
            drive_reqs();
            bus.m_ack   = late_ack;
            bus.m_rdata = $urandom;
            bus.m_stall = 1'($urandom_range(1, 0));

            if (pend_i && pend_d) win_d = RR ? !last_d : 1'b1;
            else                  win_d = pend_d;
            last_d = win_d;
            #1;
            chk("idle_cyc", bus.m_cyc, 1'b0);
            chk("idle_resp", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 4'b0000);
            chk("grant_stall", bus.d_stall, !win_d);
            late_ack = 0;

            s     = $urandom_range(3, 0);
            a     = $urandom_range(4, 1);
            k     = s + 1 + a;
            never = ($urandom_range(9, 0) == 0);
            abort = win_d && ($urandom_range(5, 0) == 0);
            ab    = $urandom_range(k, 1);
            exp_addr = win_d ? da : ia;
            exp_ctl  = win_d ? {dwe, dsel, dwd} : {1'b0, 4'b1111, 32'd0};

            for (int c = 1; c <= TO; c++) begin
                @(negedge clk);
                bus.m_stall = (c <= s);
                bus.m_ack   = !never && (c == k);
                rdata       = $urandom;
                bus.m_rdata = rdata;
                if (abort && c == ab) begin
                    bus.d_cyc = 0;
                    bus.d_stb = 0;
                end
                #1;
                chk("busy_cyc", bus.m_cyc, 1'b1);
                chk("busy_stb", bus.m_stb, c <= s + 1);
                chk("busy_stall", bus.d_stall, 1'b1);
                if (c <= s + 1) begin
                    chk("m_addr", bus.m_addr, exp_addr);
                    chk("m_ctl", {bus.m_we, bus.m_sel, bus.m_wdata}, exp_ctl);
                end
                if (abort && c == ab) begin
                    chk("abort_resp", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 4'b0000);
                    pend_d   = 0;
                    late_ack = 1'($urandom_range(1, 0));
                    break;
                end else if (!never && c == k) begin
                    chk("ack_resp", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err},
                        win_d ? 4'b0010 : 4'b1000);
                    chk("i_data", bus.i_data, win_d ? 32'd0 : rdata);
                    chk("d_rdata", bus.d_rdata, win_d ? rdata : 32'd0);
                    if (win_d) pend_d = 0; else pend_i = 0;
                    break;
                end else if (c == TO) begin
                    chk("tmo_resp", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err},
                        win_d ? 4'b0001 : 4'b0100);
                    if (win_d) pend_d = 0; else pend_i = 0;
                    late_ack = 1;
                    break;
                end else begin
                    chk("wait_resp", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 4'b0000);
                end
            end
        end

        // reset while a fetch sits in WAIT
        @(negedge clk);
        pend_d = 0; pend_i = 1; ia = 32'h100;
        drive_reqs();
        bus.m_ack = late_ack; bus.m_stall = 0;
        #1;
        chk("rst_t_idle", bus.m_cyc, 1'b0);
        @(negedge clk);
        bus.m_ack = 0;
        #1;
        chk("rst_t_req", {bus.m_stb, bus.m_addr}, {1'b1, 32'h100});
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_t_wait", {bus.m_cyc, bus.m_stb, bus.i_ack}, 3'b100);
        @(negedge clk);
        bus.m_ack = 1; bus.d_cyc = 1; bus.d_stb = 1;
        #1;
        chk("rst_t_ctl", {bus.m_cyc, bus.m_stb}, 2'b00);
        chk("rst_t_resp", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 4'b0000);
        chk("rst_t_stall", bus.d_stall, 1'b1);
        @(negedge clk);
        rst = 0;
        pend_i = 0;
        drive_reqs();
        bus.m_ack = 1;
        #1;
        chk("rst_t_late", {bus.m_cyc, bus.i_ack, bus.d_ack}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles to wait for m_ack before aborting; legal range 2..255.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_stb  in  1  fetch request, held high until i_ack or i_err.
REQ-005 i_addr  in  32  fetch byte address.
REQ-006 i_ack  out  1  fetch complete; i_data valid this cycle.
REQ-007 i_err  out  1  fetch timed out.
REQ-008 i_data  out  32  fetched instruction.
REQ-009 d_cyc  in  1  data bus cycle active.
REQ-010 d_stb  in  1  data request.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_sel  in  4  byte strobes {b3,b2,b1,b0}.
REQ-015 d_ack  out  1  data transfer complete; d_rdata valid for reads.
REQ-016 d_stall  out  1  data request not accepted this cycle.
REQ-017 d_err  out  1  data transfer timed out.
REQ-018 d_rdata  out  32  load data.
REQ-019 m_cyc, m_stb, m_we  out  1 each  single-port memory bus controls.
REQ-020 m_addr, m_wdata  out  32 each; m_sel  out  4.
REQ-021 m_ack, m_stall  in  1 each; m_rdata  in  32.

Function
REQ-022 FSM states: IDLE, REQ (m_stb high), WAIT (awaiting m_ack); one outstanding transfer only.
REQ-023 IDLE: when i_stb or (d_cyc & d_stb) is high, select the winner per REQ-032/033, latch owner, address, we, wdata, sel, and go to REQ next cycle.
REQ-024 Fetch is always a read: m_we=0, m_sel=4'b1111.
REQ-025 d_stall=0 only in IDLE cycles in which the data request wins; 1 otherwise.
REQ-026 REQ: m_stb=1 with latched fields; go to WAIT on the first cycle m_stall=0.
REQ-027 WAIT: on m_ack, pulse i_ack or d_ack (per owner) combinationally in the same cycle; pass m_rdata to i_data/d_rdata; go to IDLE.
REQ-028 m_cyc = (state != IDLE); m_stb = (state == REQ).
REQ-029 The timeout counter clears on entry to REQ and increments each REQ/WAIT cycle; at TIMEOUT_CYCLES without m_ack, pulse i_err or d_err for 1 cycle and go to IDLE.
REQ-030 If owner is D and d_cyc falls in REQ or WAIT, abort to IDLE next cycle with no d_ack/d_err; a late m_ack is ignored.
REQ-031 Any m_ack in IDLE is ignored. Acks and errors never go to a non-owner. Outputs are 0 when not asserted.

Configuration
REQ-032 Without ARB_ROUND_ROBIN_EN: fixed priority; data wins simultaneous requests.
REQ-033 With ARB_ROUND_ROBIN_EN: last_grant register; a simultaneous request goes to the requester not granted last; an uncontested request always wins.

Reset
REQ-034 rst forces IDLE, counter=0, last_grant=I, owner=I; i_ack, i_err, d_ack, d_err, m_cyc, m_stb=0; d_stall=1.
REQ-035 rst mid-transfer abandons the transfer with no ack or err; a late m_ack after reset is ignored.

Structure
REQ-036 Package mem_arb_pkg holds the state enum (IDLE/REQ/WAIT) and the owner enum (OWN_I/OWN_D).
REQ-037 One sub-module, mem_arb_timer: the timeout counter with clear/enable inputs and an expired output.

Verification
REQ-038 i_stb=1, i_addr=0x100; memory acks 2 cycles after m_stb -> m_addr=0x100, m_we=0, i_ack with i_data=m_rdata, d_ack=0.
REQ-039 i_stb and d_stb rise together, d_addr=0x2000, d_we=1, d_sel=4'b0011; macro off -> data is granted first and fetch follows; macro on with last_grant=D -> fetch is granted first.
REQ-040 m_stall=1 for 3 cycles in REQ -> m_stb held with stable m_addr; transition to WAIT only after m_stall=0.
REQ-041 Memory never acks, TIMEOUT_CYCLES=16 -> d_err pulses 1 cycle at the 16th REQ/WAIT cycle; FSM returns to IDLE; a later m_ack is ignored.
REQ-042 d_cyc drops in WAIT -> m_cyc=0 next cycle, no d_ack; a late m_ack is ignored; a pending i_stb is served afterwards.
REQ-043 rst asserted in WAIT -> all outputs at reset values next cycle; no i_ack or d_ack for the abandoned transfer.
